// File: rtl/disp_pkg.sv
// disp_pkg: shared FSM states, BCD constants and display-range helper
// for the display scan controller. No ports; imported by disp_scan_ctrl
// and bin2bcd_seq.
package disp_pkg;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_OVF_CODE = 4'hF;
  // Largest value representable on the display: 10^digits - 1.
  function automatic logic [63:0] max_disp(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bin, load  value to convert, one-cycle start request (ignored while busy)
//   bcd        converted digits, or all BCD_OVF_CODE when out of range
//   ovf        value exceeded the display range
//   busy       conversion in progress (registered)
//   done       high during the cycle whose closing edge publishes bcd/ovf
module bin2bcd_seq
  import disp_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BIN_W-1:0]        bin,
  input  logic                    load,
  output logic [DIGITS*BCD_W-1:0] bcd,
  output logic                    ovf,
  output logic                    busy,
  output logic                    done
);
  localparam int DW = DIGITS * BCD_W;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [63:0] MAXV = max_disp(DIGITS);
  state_t state, state_nx;
  logic [BIN_W-1:0] sh;
  logic [DW-1:0] acc, adj;
  logic [CW-1:0] cnt;
  logic cmp;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (load ? CONV : IDLE) :
               state == CONV ? (cnt == CW'(BIN_W - 1) ? DONE : CONV) : IDLE;
  end
  // Add-3 correction applied to every nibble before each shift.
  always_comb begin
    adj = acc;
    for (int i = 0; i < DIGITS; i++)
      adj[i*BCD_W +: BCD_W] = acc[i*BCD_W +: BCD_W] >= 4'd5 ?
                              acc[i*BCD_W +: BCD_W] + 4'd3 : acc[i*BCD_W +: BCD_W];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh   <= '0;
      acc  <= '0;
      cnt  <= '0;
      cmp  <= 1'b0;
      busy <= 1'b0;
    end else if (state == IDLE && load) begin
      sh   <= bin;
      acc  <= '0;
      cnt  <= '0;
      cmp  <= 64'(bin) > MAXV;
      busy <= 1'b1;
    end else if (state == CONV) begin
      // Bit shifted out of the top nibble is dropped; range is covered by cmp.
      {acc, sh} <= {adj[DW-2:0], sh, 1'b0};
      cnt       <= cnt + CW'(1);
    end else if (state == DONE) begin
      busy <= 1'b0;
    end
  assign bcd  = cmp ? {DIGITS{BCD_OVF_CODE}} : acc;
  assign ovf  = cmp;
  assign done = state == DONE;
endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: converts a binary value to BCD and time-multiplexes it
// onto a 4511-style decoder driving DIGITS common-anode digits.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   bin, load   value to display, one-cycle load request
//   lamp_test   active-high lamp-test request
//   D           BCD nibble to decoder
//   LE          decoder latch enable (1 = latch)
//   BL          decoder blanking, active-low
//   LT          decoder lamp test, active-low
//   AN          digit select, active-low
//   busy        conversion in progress
//   ovf         displayed value exceeds 10^DIGITS-1 (shown as blank digits)
// Build option: define DISP_SCAN_LEAD_ZERO_BLANK_EN to blank leading zeros.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int BIN_W   = 14,
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 1000,
  parameter int GUARD   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BIN_W-1:0]  bin,
  input  logic              load,
  input  logic              lamp_test,
  output logic [3:0]        D,
  output logic              LE,
  output logic              BL,
  output logic              LT,
  output logic [DIGITS-1:0] AN,
  output logic              busy,
  output logic              ovf
);
  localparam int DW = DIGITS * BCD_W;
  localparam int VW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [VW-1:0] div, div_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [DW-1:0] dig_reg, conv_bcd;
  logic conv_ovf, done, wrap, lit_nx;
  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_conv (
    .clk  (clk),
    .rst  (rst),
    .bin  (bin),
    .load (load),
    .bcd  (conv_bcd),
    .ovf  (conv_ovf),
    .busy (busy),
    .done (done)
  );
  // Outputs are registered from the next scan position so they line up
  // with the divider value they describe.
  always_comb begin
    wrap   = div == VW'(CLK_DIV - 1);
    div_nx = wrap ? '0 : div + VW'(1);
    idx_nx = wrap ? (idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1)) : idx;
    lit_nx = div_nx >= VW'(GUARD);
  end
`ifdef DISP_SCAN_LEAD_ZERO_BLANK_EN
  logic lz, lz_nx;
  // A digit is a leading zero when it and every higher digit are zero.
  always_comb begin
    lz_nx = idx_nx != '0 && (dig_reg >> (idx_nx * BCD_W)) == '0;
  end
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div     <= '0;
      idx     <= '0;
      dig_reg <= '0;
      ovf     <= 1'b0;
      D       <= '0;
      LE      <= 1'b1;
      BL      <= 1'b0;
      LT      <= 1'b1;
      AN      <= '1;
`ifdef DISP_SCAN_LEAD_ZERO_BLANK_EN
      lz      <= 1'b0;
`endif
    end else begin
      div <= div_nx;
      idx <= idx_nx;
      if (done) begin
        dig_reg <= conv_bcd;
        ovf     <= conv_ovf;
      end
      // Digit is sampled only at slot start, so D never changes mid-slot.
      if (div_nx == '0) begin
        D <= dig_reg[idx_nx*BCD_W +: BCD_W];
`ifdef DISP_SCAN_LEAD_ZERO_BLANK_EN
        lz <= lz_nx;
`endif
      end
      LE <= ~lit_nx;
`ifdef DISP_SCAN_LEAD_ZERO_BLANK_EN
      BL <= lit_nx & ~lz;
`else
      BL <= lit_nx;
`endif
      AN <= lit_nx ? ~(DIGITS'(1) << idx_nx) : '1;
      LT <= ~lamp_test;
    end
endmodule
